pwm_rgb_driver: RTL and testbench

PWM_RGB_DRIVER -- requirements
Module: pwm_rgb_driver

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_compare.sv | 23 ++
 rtl/pwm_rgb_driver.sv | 104 ++++++++++
 tb/tb_pwm_rgb_driver.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type, default sizing and phase helper for the RGB PWM driver.
package pwm_pkg;

    localparam int DEFAULT_PWM_INTERVAL = 1000;
    localparam int DEFAULT_NUM_CH       = 3;

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } pwm_state_e;

    // Start-of-period phase shift for channel ch when channels are staggered evenly.
    function automatic int phase_offset(input int ch, input int interval, input int num_ch);
        return ch * (interval / num_ch);
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// pwm_compare: one PWM channel, registered (phase count < duty) comparator.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int DW = $clog2(DEFAULT_PWM_INTERVAL)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] phase_cnt,
    input  logic [DW-1:0] duty,
    output logic          pwm
);

    // Duty at or above the period length never loses the compare, so it saturates high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (phase_cnt < duty);
        end
    end

endmodule

// File: rtl/pwm_rgb_driver.sv
// pwm_rgb_driver: NUM_CH PWM outputs with shadow/active duty buffering, updated only at the period wrap.
// Build macro PWM_PHASE_OFFSET_EN staggers channel i by i*(PWM_INTERVAL/NUM_CH) counts.
//
// state   | meaning
// EMPTY   | shadow register free; duty_ready high, next valid duty set is captured
// PENDING | shadow holds a duty set waiting to be copied to active at cnt == PWM_INTERVAL-1
module pwm_rgb_driver
    import pwm_pkg::*;
#(
    parameter  int PWM_INTERVAL = DEFAULT_PWM_INTERVAL,
    parameter  int NUM_CH       = DEFAULT_NUM_CH,
    localparam int DW           = $clog2(PWM_INTERVAL)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH*DW-1:0] duty_in,
    input  logic               duty_valid,
    output logic               duty_ready,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               period_start
);

    localparam logic [DW-1:0] CNT_MAX = DW'(PWM_INTERVAL - 1);

    pwm_state_e            state;
    logic [DW-1:0]         cnt;
    logic                  wrap;
    logic [NUM_CH*DW-1:0]  shadow_duty;
    logic [NUM_CH*DW-1:0]  active_duty;

    assign wrap       = (cnt == CNT_MAX);
    assign duty_ready = (state == EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

    // A set accepted on the wrap cycle itself lands in PENDING and waits a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            shadow_duty <= '0;
            active_duty <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (duty_valid) begin
                        shadow_duty <= duty_in;
                        state       <= PENDING;
                    end
                end
                PENDING: begin
                    if (wrap) begin
                        active_duty <= shadow_duty;
                        state       <= EMPTY;
                    end
                end
            endcase
        end
    end

    // Registered alongside the comparators so it lines up with pwm_out for cnt == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == '0);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DW-1:0] phase_cnt;

`ifdef PWM_PHASE_OFFSET_EN
        localparam int          DW1    = DW + 1;
        localparam logic [DW:0] OFFSET = DW1'(phase_offset(i, PWM_INTERVAL, NUM_CH));
        localparam logic [DW:0] LIMIT  = DW1'(PWM_INTERVAL);
        logic [DW:0] phase_sum;

        // One extra bit holds cnt + offset (< 2*PWM_INTERVAL); a single subtract wraps it.
        assign phase_sum = {1'b0, cnt} + OFFSET;
        assign phase_cnt = (phase_sum >= LIMIT) ? DW'(phase_sum - LIMIT) : DW'(phase_sum);
`else
        assign phase_cnt = cnt;
`endif

        pwm_compare #(
            .DW(DW)
        ) u_cmp (
            .clk       (clk),
            .rst       (rst),
            .phase_cnt (phase_cnt),
            .duty      (active_duty[i*DW +: DW]),
            .pwm       (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_rgb_driver.sv
// tb_pwm_rgb_driver: cycle scoreboard against a reference model plus directed period measurements.
module tb_pwm_rgb_driver;

    localparam int PI = 1000;
    localparam int NC = 3;
    localparam int DW = 10;
`ifdef PWM_PHASE_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic [NC*DW-1:0]  duty_in    = '0;
    logic              duty_valid = 1'b0;
    logic              duty_ready;
    logic [NC-1:0]     pwm_out;
    logic              period_start;

    int checks = 0;
    int errors = 0;

    int m_cnt     = 0;
    bit m_pending = 1'b0;
    int m_shadow[NC] = '{default: 0};
    int m_active[NC] = '{default: 0};
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    pwm_rgb_driver #(
        .PWM_INTERVAL (PI),
        .NUM_CH       (NC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    function automatic int phase_of(input int c, input int ch);
        if (OFFSET_EN) return (c + ch * (PI / NC)) % PI;
        return c;
    endfunction

    // Reference model: pushes the outputs expected right after each rising edge.
    always @(posedge clk) begin : ref_model
        logic [NC-1:0] ep;
        logic          eps;
        ep  = '0;
        eps = 1'b0;
        if (rst) begin
            m_cnt     = 0;
            m_pending = 1'b0;
            for (int i = 0; i < NC; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
        end else begin
            for (int i = 0; i < NC; i++) ep[i] = (phase_of(m_cnt, i) < m_active[i]);
            eps = (m_cnt == 0);
            if (m_pending && m_cnt == PI - 1) begin
                for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0;
            end else if (!m_pending && duty_valid) begin
                for (int i = 0; i < NC; i++) m_shadow[i] = int'(duty_in[i*DW +: DW]);
                m_pending = 1'b1;
            end
            m_cnt = (m_cnt == PI - 1) ? 0 : m_cnt + 1;
        end
        sb_q.push_back({ep, eps, ~m_pending});
    end

    always @(negedge clk) begin : sb_check
        logic [4:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({pwm_out, period_start, duty_ready} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t model_cnt=%0d: pwm/ps/rdy=%b, required %b",
                         $time, m_cnt, {pwm_out, period_start, duty_ready}, e);
            end
        end
    end

    task automatic wait_cnt(input int target);
        int k = 0;
        while (m_cnt != target && k < 1100) begin
            @(negedge clk);
            k++;
        end
        if (m_cnt != target) begin
            errors++;
            $display("FAIL wait_cnt: model cnt=%0d, required %0d", m_cnt, target);
        end
    endtask

    task automatic load_duty(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        duty_in    = {d2, d1, d0};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        duty_in    = '0;
    endtask

    // Waits (bounded) for period_start, then counts high cycles per channel over one period.
    task automatic measure_period(output int h0, output int h1, output int h2, output bit timeout);
        int k = 0;
        h0 = 0; h1 = 0; h2 = 0;
        while (period_start !== 1'b1 && k < 1100) begin
            @(negedge clk);
            k++;
        end
        timeout = (period_start !== 1'b1);
        for (int n = 0; n < PI; n++) begin
            if (pwm_out[0] === 1'b1) h0++;
            if (pwm_out[1] === 1'b1) h1++;
            if (pwm_out[2] === 1'b1) h2++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad_ps = 0, bad_pwm = 0, bad_rdy = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 3'b000 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pwm_out=%b period_start=%b, required 000/0", pwm_out, period_start);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: duty_ready=%b, required 1", duty_ready);
        end
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_period_start: period_start=%b, required 1", period_start);
        end
        for (int k = 1; k <= 2 * PI; k++) begin
            @(negedge clk);
            if (period_start !== ((k % PI) == 0)) bad_ps++;
            if (pwm_out !== 3'b000) bad_pwm++;
            if (duty_ready !== 1'b1) bad_rdy++;
        end
        checks++;
        if (bad_ps != 0) begin
            errors++;
            $display("FAIL reset_ps_spacing: %0d misplaced period_start cycles, required 0", bad_ps);
        end
        checks++;
        if (bad_pwm != 0) begin
            errors++;
            $display("FAIL reset_pwm_idle: %0d cycles with pwm_out high, required 0", bad_pwm);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL reset_ready_idle: %0d cycles with duty_ready low, required 0", bad_rdy);
        end
    endtask

    task automatic test_load_at_10();
        int k = 0, ready_hi = 0, h0, h1, h2;
        bit to;
        wait_cnt(10);
        load_duty(10'd250, 10'd500, 10'd1000);
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_low: duty_ready=%b, required 0", duty_ready);
        end
        while (period_start !== 1'b1 && k < 1100) begin
            if (duty_ready !== 1'b0) ready_hi++;
            @(negedge clk);
            k++;
        end
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap_timeout: period_start=%b after %0d cycles, required 1", period_start, k);
        end
        // duty_ready rises on the wrap edge, one cycle ahead of period_start.
        checks++;
        if (ready_hi != 1) begin
            errors++;
            $display("FAIL load_ready_window: %0d ready-high cycles before period_start, required 1", ready_hi);
        end
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 250) begin
            errors++;
            $display("FAIL load_r_high: %0d cycles (timeout=%0d), required 250", h0, to);
        end
        checks++;
        if (h1 != 500) begin
            errors++;
            $display("FAIL load_g_high: %0d cycles, required 500", h1);
        end
        checks++;
        if (h2 != 1000 || pwm_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL load_b_continuous: %0d cycles, at wrap %b, required 1000 and 1", h2, pwm_out[2]);
        end
    endtask

    task automatic test_late_load();
        int h0, h1, h2;
        bit to;
        wait_cnt(PI - 1);
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_ready_before: duty_ready=%b, required 1", duty_ready);
        end
        load_duty(10'd100, 10'd200, 10'd300);
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL late_pending: duty_ready=%b, required 0", duty_ready);
        end
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 250 || h1 != 500 || h2 != 1000) begin
            errors++;
            $display("FAIL late_old_period: %0d/%0d/%0d (timeout=%0d), required 250/500/1000", h0, h1, h2, to);
        end
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 100 || h1 != 200 || h2 != 300) begin
            errors++;
            $display("FAIL late_new_period: %0d/%0d/%0d (timeout=%0d), required 100/200/300", h0, h1, h2, to);
        end
    endtask

    task automatic test_saturate();
        int h0, h1, h2;
        bit to;
        wait_cnt(20);
        load_duty(10'd0, 10'd1023, 10'd500);
        for (int p = 0; p < 2; p++) begin
            measure_period(h0, h1, h2, to);
            checks++;
            if (to || h0 != 0) begin
                errors++;
                $display("FAIL sat_zero_p%0d: %0d high cycles (timeout=%0d), required 0", p, h0, to);
            end
            checks++;
            if (h1 != PI || h2 != 500) begin
                errors++;
                $display("FAIL sat_full_p%0d: %0d/%0d high cycles, required 1000/500", p, h1, h2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int h0, h1, h2, bad_rdy = 0;
        bit to;
        wait_cnt(50);
        duty_in    = {10'd40, 10'd30, 10'd20};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_in = {10'd900, 10'd900, 10'd900};
        for (int k = 0; k < 100; k++) begin
            if (duty_ready !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        duty_valid = 1'b0;
        duty_in    = '0;
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL b2b_ready_pending: %0d ready-high cycles while pending, required 0", bad_rdy);
        end
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 20 || h1 != 30 || h2 != 40) begin
            errors++;
            $display("FAIL b2b_first_kept: %0d/%0d/%0d (timeout=%0d), required 20/30/40", h0, h1, h2, to);
        end
    endtask

    task automatic test_reset_pending();
        int h0, h1, h2;
        bit to;
        wait_cnt(100);
        load_duty(10'd700, 10'd700, 10'd700);
        wait_cnt(600);
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstp_pending: duty_ready=%b, required 0", duty_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm_out !== 3'b000 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL rstp_outputs: pwm_out=%b period_start=%b, required 000/0", pwm_out, period_start);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (duty_ready !== 1'b1 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL rstp_restart: duty_ready=%b period_start=%b, required 1/1", duty_ready, period_start);
        end
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 0 || h1 != 0 || h2 != 0) begin
            errors++;
            $display("FAIL rstp_shadow_discarded: %0d/%0d/%0d (timeout=%0d), required 0/0/0", h0, h1, h2, to);
        end
    endtask

`ifdef PWM_PHASE_OFFSET_EN
    task automatic test_phase_offset();
        int h0, h1, h2, f0 = -1, f1 = -1, f2 = -1;
        bit to;
        wait_cnt(10);
        load_duty(10'd100, 10'd100, 10'd100);
        measure_period(h0, h1, h2, to);
        checks++;
        if (to || h0 != 100 || h1 != 100 || h2 != 100) begin
            errors++;
            $display("FAIL phase_counts: %0d/%0d/%0d (timeout=%0d), required 100/100/100", h0, h1, h2, to);
        end
        for (int n = 0; n < PI; n++) begin
            if (pwm_out[0] === 1'b1 && f0 < 0) f0 = n;
            if (pwm_out[1] === 1'b1 && f1 < 0) f1 = n;
            if (pwm_out[2] === 1'b1 && f2 < 0) f2 = n;
            @(negedge clk);
        end
        checks++;
        if (f0 != 0 || f1 - f0 != 667) begin
            errors++;
            $display("FAIL phase_ch1_lag: ch0 rise %0d ch1 rise %0d, required 0 and lag 667", f0, f1);
        end
        checks++;
        if (f2 - f0 != 334) begin
            errors++;
            $display("FAIL phase_ch2_lag: lag %0d, required 334", f2 - f0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_at_10();
        test_late_load();
        test_saturate();
        test_back_to_back();
        test_reset_pending();
`ifdef PWM_PHASE_OFFSET_EN
        test_phase_offset();
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached at t=%0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
